// File: rtl/rvx_core_bus_arbiter.sv
// Shares one memory port between the instruction and data buses; a batch of requests is served in turn and answered together.
// Build option RVX_BUS_ARBITER_FAST_RESPONSE_EN forwards a lone master's mem response combinationally and skips RESPOND.
//
// state       | meaning
// IDLE        | waiting for requests; latches the batch on first sight
// DBUS_ACCESS | latched data-bus access on the mem port
// IBUS_ACCESS | latched instruction fetch on the mem port
// RESPOND     | one-cycle coincident responses for the whole batch
module rvx_core_bus_arbiter #(
  parameter bit DBUS_PRIORITY = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ibus_address,
  input  logic        ibus_rrequest,
  output logic [31:0] ibus_rdata,
  output logic        ibus_rresponse,
  input  logic [31:0] dbus_address,
  input  logic        dbus_rrequest,
  input  logic        dbus_wrequest,
  input  logic [31:0] dbus_wdata,
  input  logic [3:0]  dbus_wstrobe,
  output logic [31:0] dbus_rdata,
  output logic        dbus_rresponse,
  output logic        dbus_wresponse,
  output logic [31:0] mem_address,
  output logic        mem_rrequest,
  output logic        mem_wrequest,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rresponse,
  input  logic        mem_wresponse
);

`ifdef RVX_BUS_ARBITER_FAST_RESPONSE_EN
  localparam bit FAST_RESPONSE = 1'b1;
`else
  localparam bit FAST_RESPONSE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DBUS_ACCESS, IBUS_ACCESS, RESPOND} state_t;

  state_t      state, state_nxt;
  logic        pend_i, pend_d, op_write;
  logic [31:0] addr_i, addr_d, wdata_d, buf_i, buf_d;
  logic [3:0]  wstrobe_d;
  logic        req_i, req_d, batch_start, d_done, i_done, single;

  assign req_i       = ibus_rrequest;
  assign req_d       = dbus_rrequest | dbus_wrequest;
  assign batch_start = (state == IDLE) && (req_i || req_d);
  assign d_done      = (state == DBUS_ACCESS) && (op_write ? mem_wresponse : mem_rresponse);
  assign i_done      = (state == IBUS_ACCESS) && mem_rresponse;
  assign single      = pend_i ^ pend_d;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_d && (DBUS_PRIORITY || !req_i)) state_nxt = DBUS_ACCESS;
        else if (req_i)                         state_nxt = IBUS_ACCESS;
      end
      DBUS_ACCESS: begin
        if (d_done) begin
          if (DBUS_PRIORITY && pend_i)       state_nxt = IBUS_ACCESS;
          else if (FAST_RESPONSE && single)  state_nxt = IDLE;
          else                               state_nxt = RESPOND;
        end
      end
      IBUS_ACCESS: begin
        if (i_done) begin
          if (!DBUS_PRIORITY && pend_d)      state_nxt = DBUS_ACCESS;
          else if (FAST_RESPONSE && single)  state_nxt = IDLE;
          else                               state_nxt = RESPOND;
        end
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffers are cleared per batch so a master not in the batch reads 0 in RESPOND.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_i    <= 1'b0;
      pend_d    <= 1'b0;
      op_write  <= 1'b0;
      addr_i    <= '0;
      addr_d    <= '0;
      wdata_d   <= '0;
      wstrobe_d <= '0;
      buf_i     <= '0;
      buf_d     <= '0;
    end else begin
      if (batch_start) begin
        pend_i    <= req_i;
        pend_d    <= req_d;
        op_write  <= dbus_wrequest;
        addr_i    <= ibus_address;
        addr_d    <= dbus_address;
        wdata_d   <= dbus_wdata;
        wstrobe_d <= dbus_wstrobe;
        buf_i     <= '0;
        buf_d     <= '0;
      end
      if (d_done && !op_write) buf_d <= mem_rdata;
      if (i_done)              buf_i <= mem_rdata;
      if (state != IDLE && state_nxt == IDLE) begin
        pend_i <= 1'b0;
        pend_d <= 1'b0;
      end
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_rrequest   = 1'b0;
    mem_wrequest   = 1'b0;
    mem_wdata      = '0;
    mem_wstrobe    = '0;
    ibus_rdata     = '0;
    ibus_rresponse = 1'b0;
    dbus_rdata     = '0;
    dbus_rresponse = 1'b0;
    dbus_wresponse = 1'b0;
    unique case (state)
      DBUS_ACCESS: begin
        mem_address  = addr_d;
        mem_rrequest = !op_write;
        mem_wrequest = op_write;
        if (op_write) begin
          mem_wdata   = wdata_d;
          mem_wstrobe = wstrobe_d;
        end
        if (FAST_RESPONSE && single) begin
          dbus_rresponse = d_done && !op_write;
          dbus_wresponse = d_done && op_write;
          if (d_done && !op_write) dbus_rdata = mem_rdata;
        end
      end
      IBUS_ACCESS: begin
        mem_address  = addr_i;
        mem_rrequest = 1'b1;
        if (FAST_RESPONSE && single) begin
          ibus_rresponse = i_done;
          if (i_done) ibus_rdata = mem_rdata;
        end
      end
      RESPOND: begin
        ibus_rresponse = pend_i;
        dbus_rresponse = pend_d && !op_write;
        dbus_wresponse = pend_d && op_write;
        ibus_rdata     = buf_i;
        dbus_rdata     = buf_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rvx_core_bus_arbiter.sv
// Randomized bench for rvx_core_bus_arbiter: a schedule model derives every mem access window and response cycle per batch.
// Honours RVX_BUS_ARBITER_FAST_RESPONSE_EN and the DBUS_PRIO bench parameter.
module tb_rvx_core_bus_arbiter;
  parameter bit DBUS_PRIO = 1'b1;
`ifdef RVX_BUS_ARBITER_FAST_RESPONSE_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clock, reset;
  logic [31:0] ibus_address, ibus_rdata;
  logic        ibus_rrequest, ibus_rresponse;
  logic [31:0] dbus_address, dbus_wdata, dbus_rdata;
  logic        dbus_rrequest, dbus_wrequest, dbus_rresponse, dbus_wresponse;
  logic [3:0]  dbus_wstrobe, mem_wstrobe;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_rrequest, mem_wrequest, mem_rresponse, mem_wresponse;

  rvx_core_bus_arbiter #(.DBUS_PRIORITY(DBUS_PRIO)) dut (
    .clock(clock), .reset(reset),
    .ibus_address(ibus_address), .ibus_rrequest(ibus_rrequest),
    .ibus_rdata(ibus_rdata), .ibus_rresponse(ibus_rresponse),
    .dbus_address(dbus_address), .dbus_rrequest(dbus_rrequest), .dbus_wrequest(dbus_wrequest),
    .dbus_wdata(dbus_wdata), .dbus_wstrobe(dbus_wstrobe), .dbus_rdata(dbus_rdata),
    .dbus_rresponse(dbus_rresponse), .dbus_wresponse(dbus_wresponse),
    .mem_address(mem_address), .mem_rrequest(mem_rrequest), .mem_wrequest(mem_wrequest),
    .mem_wdata(mem_wdata), .mem_wstrobe(mem_wstrobe), .mem_rdata(mem_rdata),
    .mem_rresponse(mem_rresponse), .mem_wresponse(mem_wresponse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0, n_mis = 0, cyc = 0;

  // Expected schedule of the current batch.
  int          acc_n = 0;
  int          a_start[2], a_k[2];
  bit          a_wr[2];
  logic [31:0] a_addr[2], a_wdata[2], a_rdata[2];
  logic [3:0]  a_strb[2];
  bit          b_pi, b_pd, b_dw;
  logic [31:0] b_ri, b_rd;
  int          b_resp = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic release_masters();
    ibus_rrequest = 1'b0;
    dbus_rrequest = 1'b0;
    dbus_wrequest = 1'b0;
  endtask

  task automatic check_responses(input int c);
    bit hit;
    hit = (c == b_resp);
    check("ibus_rresponse", {31'd0, ibus_rresponse}, {31'd0, hit && b_pi});
    check("dbus_rresponse", {31'd0, dbus_rresponse}, {31'd0, hit && b_pd && !b_dw});
    check("dbus_wresponse", {31'd0, dbus_wresponse}, {31'd0, hit && b_pd && b_dw});
    check("ibus_rdata", ibus_rdata, (hit && b_pi) ? b_ri : 32'd0);
    check("dbus_rdata", dbus_rdata, (hit && b_pd && !b_dw) ? b_rd : 32'd0);
  endtask

  // Slave plays the schedule (with non-matching strays), then all outputs are compared.
  task automatic drive_and_check(input int c);
    int j;
    bit rr, wr, last;
    logic [31:0] rd;
    j = -1;
    for (int a = 0; a < acc_n; a++)
      if (c >= a_start[a] && c <= a_start[a] + a_k[a]) j = a;
    rd = $urandom;
    if (j >= 0) begin
      last = (c == a_start[j] + a_k[j]);
      if (a_wr[j]) begin
        wr = last;
        rr = ($urandom_range(0, 2) == 0);
      end else begin
        rr = last;
        wr = ($urandom_range(0, 2) == 0);
        if (last) rd = a_rdata[j];
      end
    end else begin
      rr = ($urandom_range(0, 3) == 0);
      wr = ($urandom_range(0, 3) == 0);
    end
    mem_rresponse = rr;
    mem_wresponse = wr;
    mem_rdata     = rd;
    #1;
    check("mem_rrequest", {31'd0, mem_rrequest}, {31'd0, j >= 0 && !a_wr[j]});
    check("mem_wrequest", {31'd0, mem_wrequest}, {31'd0, j >= 0 && a_wr[j]});
    if (j >= 0) begin
      check("mem_address", mem_address, a_addr[j]);
      check("mem_wdata", mem_wdata, a_wr[j] ? a_wdata[j] : 32'd0);
      check("mem_wstrobe", {28'd0, mem_wstrobe}, a_wr[j] ? {28'd0, a_strb[j]} : 32'd0);
    end
    check_responses(c);
  endtask

  // dop: 0 none, 1 read, 2 write, 3 read+write (write wins). gap < 0 presents the batch in the previous response cycle.
  task automatic run_batch(input bit pi, input int dop, input logic [31:0] ai, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [3:0] ws, input int ki, input int kd,
                           input logic [31:0] ri, input logic [31:0] rdd, input int gap, input bit drop);
    int t, s, n;
    int order[2];
    if (gap >= 0) begin
      release_masters();
      for (int g = 0; g < gap; g++) begin
        next_cycle();
        drive_and_check(cyc);
      end
      next_cycle();
    end
    ibus_rrequest = pi;
    ibus_address  = ai;
    dbus_rrequest = (dop == 1) || (dop == 3);
    dbus_wrequest = (dop >= 2);
    dbus_address  = ad;
    dbus_wdata    = wd;
    dbus_wstrobe  = ws;
    if (gap < 0) next_cycle();
    t = cyc;
    b_pi = pi; b_pd = (dop != 0); b_dw = (dop >= 2); b_ri = ri; b_rd = rdd;
    n = 0;
    if (b_pi && b_pd) begin
      order[0] = DBUS_PRIO ? 1 : 0;
      order[1] = DBUS_PRIO ? 0 : 1;
      n = 2;
    end else begin
      order[0] = b_pd ? 1 : 0;
      n = 1;
    end
    s = t + 1;
    for (int a = 0; a < n; a++) begin
      a_start[a] = s;
      if (order[a] == 1) begin
        a_k[a] = kd; a_wr[a] = b_dw; a_addr[a] = ad; a_wdata[a] = wd; a_strb[a] = ws; a_rdata[a] = rdd;
      end else begin
        a_k[a] = ki; a_wr[a] = 1'b0; a_addr[a] = ai; a_wdata[a] = 32'd0; a_strb[a] = 4'd0; a_rdata[a] = ri;
      end
      s = s + a_k[a] + 1;
    end
    acc_n = n;
    b_resp = (n == 1 && FAST) ? s - 1 : s;
    for (int c = t; c <= b_resp; c++) begin
      if (c > t) next_cycle();
      drive_and_check(cyc);
      if (drop && c == t + 1) release_masters();
    end
  endtask

  initial begin
    logic [31:0] r0;
    reset = 1'b1;
    release_masters();
    ibus_address = '0; dbus_address = '0; dbus_wdata = '0; dbus_wstrobe = '0;
    mem_rdata = '0; mem_rresponse = 1'b0; mem_wresponse = 1'b0;
    repeat (3) next_cycle();
    check("reset mem_rrequest", {31'd0, mem_rrequest}, 32'd0);
    check("reset mem_wrequest", {31'd0, mem_wrequest}, 32'd0);
    check("reset mem_address", mem_address, 32'd0);
    check_responses(cyc);
    reset = 1'b0;

    run_batch(1'b1, 0, 32'h100, 32'h0, 32'h0, 4'h0, 1, 1, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    run_batch(1'b1, 2, 32'h200, 32'h8000, 32'h12345678, 4'hF, 1, 1, 32'h1111_2222, 32'h0, 1, 1'b0);
    run_batch(1'b1, 1, 32'h300, 32'h9000, 32'h0, 4'h0, 3, 3, 32'h0000C0DE, 32'hA5A5A5A5, 0, 1'b0);
    run_batch(1'b1, 0, 32'h100, 32'h0, 32'h0, 4'h0, 1, 1, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    run_batch(1'b1, 0, 32'h104, 32'h0, 32'h0, 4'h0, 1, 1, 32'hCAFEF00D, 32'h0, -1, 1'b0);
    run_batch(1'b0, 3, 32'h0, 32'h40, 32'hFFFF0000, 4'h3, 1, 2, 32'h0, 32'h0, 0, 1'b1);

    for (int b = 0; b < 150; b++) begin
      bit pi;
      int dop;
      pi  = $urandom_range(0, 1);
      dop = $urandom_range(0, 3);
      if (!pi && dop == 0) pi = 1'b1;
      run_batch(pi, dop, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                $urandom_range(1, 4), $urandom_range(1, 4), $urandom, $urandom,
                $urandom_range(0, 3) - 1, ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a data write abandons it with no response.
    release_masters();
    next_cycle();
    drive_and_check(cyc);
    next_cycle();
    dbus_wrequest = 1'b1; dbus_address = 32'h8000; dbus_wdata = 32'h12345678; dbus_wstrobe = 4'hF;
    acc_n = 1; a_start[0] = cyc + 1; a_k[0] = 5; a_wr[0] = 1'b1;
    a_addr[0] = 32'h8000; a_wdata[0] = 32'h12345678; a_strb[0] = 4'hF; a_rdata[0] = 32'h0;
    b_resp = -1;
    drive_and_check(cyc);
    next_cycle();
    drive_and_check(cyc);
    reset = 1'b1;
    release_masters();
    next_cycle();
    reset = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 3; i++) begin
      r0 = $urandom;
      mem_wresponse = 1'b1;
      mem_rresponse = 1'b0;
      mem_rdata = r0;
      #1;
      check("post-reset mem_wrequest", {31'd0, mem_wrequest}, 32'd0);
      check("post-reset mem_rrequest", {31'd0, mem_rrequest}, 32'd0);
      check("post-reset dbus_wresponse", {31'd0, dbus_wresponse}, 32'd0);
      check("post-reset ibus_rresponse", {31'd0, ibus_rresponse}, 32'd0);
      next_cycle();
    end
    mem_wresponse = 1'b0;
    run_batch(1'b1, 0, 32'h100, 32'h0, 32'h0, 4'h0, 1, 1, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    run_batch(1'b1, 1, 32'h300, 32'h9000, 32'h0, 4'h0, 2, 1, 32'h0000C0DE, 32'hA5A5A5A5, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
